// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encodings and the default operand width.
package serial_addsub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_addsub_pkg

// File: rtl/serial_addsub_onebit_adder.sv
// Single full-adder cell used by the serial datapath, one bit per clock.
module onebit_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Combinational full-adder sum and carry
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule : onebit_adder

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract unit. Operands are shifted LSB first through a
// single full-adder cell, one bit per RUN cycle. The sum collects in a shadow
// shift register and is published, with the flags, alongside the done pulse.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             msb_cin_q, msb_cin_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  onebit_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic: IDLE -> RUN on start, RUN for WIDTH bits, one DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // FSM outputs: busy straight from state, the rest from their registers
  always_comb begin
    busy     = (state_q == RUN) || (state_q == DONE);
    done     = done_q;
    result   = result_q;
    c_out    = c_out_q;
    overflow = ovf_q;
    zero     = zero_q;
  end

  // Datapath registers, all cleared asynchronously so a reset aborts cleanly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      shadow_q  <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      msb_cin_q <= 1'b0;
      c_out_q   <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      shadow_q  <= shadow_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      msb_cin_q <= msb_cin_d;
      c_out_q   <= c_out_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
      done_q    <= done_d;
    end
  end

  // Datapath next values: load on accepted start, one bit per RUN cycle,
  // publish the finished result and flags while leaving DONE
  always_comb begin
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    shadow_d  = shadow_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    msb_cin_d = msb_cin_q;
    c_out_d   = c_out_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = op_sub ? ~b : b;
          carry_d = op_sub;
          cnt_d   = '0;
        end
      end
      RUN: begin
        shadow_d = {fa_sum, shadow_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_bit) msb_cin_d = carry_q;
      end
      DONE: begin
        // done is registered, so the result and flags are copied on the same
        // edge that raises it; they then appear together one cycle after DONE
        result_d = shadow_q;
        c_out_d  = carry_q;
        ovf_d    = msb_cin_q ^ carry_q;
        zero_d   = (shadow_q == '0);
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule : serial_addsub

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub (WIDTH=32): the driver pushes expected
// results from a plain-arithmetic model, an independent monitor pops and
// compares whenever done is seen.
module tb_serial_addsub;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, c_out, overflow, zero;
  logic [W-1:0] result;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t last_exp;

  serial_addsub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model from the arithmetic definition: 33-bit sum, signed overflow
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
    exp_t         e;
    logic [W:0]   full;
    longint       sx, sy, sr;
    if (sub) full = {1'b0, x} + {1'b0, ~y} + 1;
    else     full = {1'b0, x} + {1'b0, y};
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    sr = sub ? sx - sy : sx + sy;
    e.res = full[W-1:0];
    e.c   = full[W];
    e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.z   = (full[W-1:0] == '0);
    e.due = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result",   64'(result),   64'(e.res));
        check("c_out",    64'(c_out),    64'(e.c));
        check("overflow", 64'(overflow), 64'(e.v));
        check("zero",     64'(zero),     64'(e.z));
        check("latency",  64'(cyc),      64'(e.due));
      end
    end
  end

  // Present one operation; returns the cycle count of the accepting edge
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub,
                       input bit expect_it, output int acc);
    exp_t e;
    @(negedge clk);
    a = x; b = y; op_sub = sub; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    acc = cyc;
    if (expect_it) begin
      e = model(x, y, sub);
      e.due = acc + W + 1;
      sb.push_back(e);
      last_exp = e;
    end
  endtask

  // Bounded wait for the scoreboard to drain, then confirm the result holds
  task automatic finish_op();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
      sb.delete();
    end
    repeat (3) @(negedge clk);
    check("result_hold", 64'(result), 64'(last_exp.res));
    check("busy_idle",   64'(busy),   64'd0);
  endtask

  initial begin
    int acc;
    logic [W-1:0] x, y;

    repeat (3) @(negedge clk);
    check("rst_busy",   64'(busy),   64'd0);
    check("rst_done",   64'(done),   64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags",  64'({c_out, overflow, zero}), 64'd0);
    rst_n = 1'b1;

    // Directed cases
    issue(32'd5, 32'd7, 1'b0, 1, acc);              finish_op();
    issue(32'd5, 32'd7, 1'b1, 1, acc);              finish_op();
    issue(32'd7, 32'd5, 1'b1, 1, acc);              finish_op();
    issue(32'h7FFFFFFF, 32'd1, 1'b0, 1, acc);       finish_op();
    issue(32'hFFFFFFFF, 32'd1, 1'b0, 1, acc);       finish_op();
    issue(32'h80000000, 32'd1, 1'b1, 1, acc);       finish_op();
    issue(32'd0, 32'd0, 1'b1, 1, acc);              finish_op();

    // Starts during RUN and during DONE are ignored
    issue(32'd1, 32'd1, 1'b0, 1, acc);
    repeat (9) @(posedge clk);
    @(negedge clk);
    a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_run", 64'(busy), 64'd1);
    check("result_not_early", 64'(result), 64'h0);
    repeat (22) @(posedge clk);
    @(negedge clk);
    check("busy_done_state", 64'(busy), 64'd1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("busy_after_done", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    finish_op();

    // Reset during RUN aborts with no done
    issue(32'd1234, 32'd4321, 1'b0, 0, acc);
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy",   64'(busy),   64'd0);
    check("abort_done",   64'(done),   64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_flags",  64'({c_out, overflow, zero}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'd3, 32'd4, 1'b0, 1, acc);              finish_op();

    // Randomised operations
    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      y = $urandom;
      if (i % 8 == 0) y = x;
      if (i % 8 == 1) x = 32'h80000000;
      issue(x, y, 1'($urandom_range(0, 1)), 1, acc);
      finish_op();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog");
  end

endmodule : tb_serial_addsub
